// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) between a manager and a subordinate.
// The interface has no logic and adds no latency.
// Each channel uses VALID/READY handshakes: a transfer happens on an edge where both are high.
interface axi4_lite_slave_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
           S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
           S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite subordinate with NUM_REGS byte-strobed registers, all exported in parallel.
// Write: B valid one cycle after the later of the AW/W handshakes. Read: R valid on the AR handshake edge.
// One write and one read outstanding; B/R are held until BREADY/RREADY, and the READYs stay low meanwhile.
module axi4_lite_slave #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi4_lite_slave_if.slave               s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  output logic [NUM_REGS-1:0]            WR_PULSE
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDRESS-1:0] SPAN = ADDRESS'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic                  w_held;
  logic [ADDRESS-1:0]    aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign aw_hs  = s_axi.S_AWVALID && s_axi.S_AWREADY;
  assign w_hs   = s_axi.S_WVALID  && s_axi.S_WREADY;
  assign b_hs   = s_axi.S_BVALID  && s_axi.S_BREADY;
  assign ar_hs  = s_axi.S_ARVALID && s_axi.S_ARREADY;
  assign r_hs   = s_axi.S_RVALID  && s_axi.S_RREADY;
  // Commit once both halves of the write are latched and no response is pending.
  assign commit = aw_held && w_held && !s_axi.S_BVALID;

  // Low alignment bits are dropped; anything at or beyond the bank size is out of range.
  assign wr_idx      = aw_addr[LSB +: IDX_W];
  assign wr_in_range = (aw_addr < SPAN);
  assign rd_idx      = s_axi.S_ARADDR[LSB +: IDX_W];
  assign rd_in_range = (s_axi.S_ARADDR < SPAN);

  // Write channel capture, commit and response handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_addr         <= '0;
      w_data          <= '0;
      w_strb          <= '0;
      s_axi.S_AWREADY <= 1'b0;
      s_axi.S_WREADY  <= 1'b0;
      s_axi.S_BVALID  <= 1'b0;
      s_axi.S_BRESP   <= RESP_OKAY;
      WR_PULSE        <= '0;
    end else begin
      WR_PULSE <= '0;

      // AW and W are captured independently; READY returns only when that side is empty
      // and the previous response has been taken.
      if (aw_hs) begin
        aw_addr         <= s_axi.S_AWADDR;
        aw_held         <= 1'b1;
        s_axi.S_AWREADY <= 1'b0;
      end else if ((!aw_held && !s_axi.S_BVALID) || b_hs) begin
        s_axi.S_AWREADY <= 1'b1;
      end

      if (w_hs) begin
        w_data         <= s_axi.S_WDATA;
        w_strb         <= s_axi.S_WSTRB;
        w_held         <= 1'b1;
        s_axi.S_WREADY <= 1'b0;
      end else if ((!w_held && !s_axi.S_BVALID) || b_hs) begin
        s_axi.S_WREADY <= 1'b1;
      end

      if (commit) begin
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        s_axi.S_BVALID <= 1'b1;
        s_axi.S_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        if (wr_in_range) WR_PULSE <= NUM_REGS'(1) << wr_idx;
      end else if (b_hs) begin
        s_axi.S_BVALID <= 1'b0;
      end
    end
  end

  // Register bank update: only strobed bytes of an in-range commit change.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) regs[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // Read path: sample on the AR edge (old value on a same-edge write), hold until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.S_ARREADY <= 1'b0;
      s_axi.S_RVALID  <= 1'b0;
      s_axi.S_RDATA   <= '0;
      s_axi.S_RRESP   <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi.S_ARREADY <= 1'b0;
      s_axi.S_RVALID  <= 1'b1;
      s_axi.S_RDATA   <= rd_in_range ? regs[rd_idx] : '0;
      s_axi.S_RRESP   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      s_axi.S_RVALID  <= 1'b0;
      s_axi.S_ARREADY <= 1'b1;
    end else if (!s_axi.S_RVALID) begin
      s_axi.S_ARREADY <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign REG_Q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: hand-computed expectations checked with immediate assertions.
// Inputs are driven 1 ns after each rising edge and outputs are sampled at that point.
// Covers reset, write ordering, strobes, out-of-range access, backpressure and reset mid-write.
module tb_axi4_lite_slave;

  logic        ACLK;
  logic        ARESETN;
  logic [255:0] REG_Q;
  logic [7:0]   WR_PULSE;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_reg [8];

  axi4_lite_slave_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .s_axi    (bus),
    .REG_Q    (REG_Q),
    .WR_PULSE (WR_PULSE)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), 64'(REG_Q[i*32 +: 32]), 64'(exp_reg[i]));
  endtask

  // Present AW and W together, release them after the handshake edge, then check the commit.
  task automatic write_both(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input logic [7:0] pulse);
    bus.S_AWADDR = addr; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = data;  bus.S_WSTRB = strb; bus.S_WVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    chk({tag, "_hs_bvalid"}, 64'(bus.S_BVALID), 64'd0);
    tick();
    chk({tag, "_bvalid"}, 64'(bus.S_BVALID), 64'd1);
    chk({tag, "_bresp"}, 64'(bus.S_BRESP), 64'(resp));
    chk({tag, "_pulse"}, 64'(WR_PULSE), 64'(pulse));
    chk_regs(tag);
    tick();
    chk({tag, "_bdone"}, 64'(bus.S_BVALID), 64'd0);
    chk({tag, "_pulse_off"}, 64'(WR_PULSE), 64'd0);
    chk({tag, "_awready"}, 64'(bus.S_AWREADY), 64'd1);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    bus.S_ARADDR = addr; bus.S_ARVALID = 1'b1;
    tick();
    bus.S_ARVALID = 1'b0;
    chk({tag, "_rvalid"}, 64'(bus.S_RVALID), 64'd1);
    chk({tag, "_rdata"}, 64'(bus.S_RDATA), 64'(data));
    chk({tag, "_rresp"}, 64'(bus.S_RRESP), 64'(resp));
    chk({tag, "_arready_lo"}, 64'(bus.S_ARREADY), 64'd0);
    tick();
    chk({tag, "_rdone"}, 64'(bus.S_RVALID), 64'd0);
    chk({tag, "_arready_hi"}, 64'(bus.S_ARREADY), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_reg[i] = 32'h0;
    ARESETN = 1'b0;
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0;  bus.S_WSTRB = '0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b1;
    bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_awready", 64'(bus.S_AWREADY), 64'd0);
    chk("rst_wready", 64'(bus.S_WREADY), 64'd0);
    chk("rst_arready", 64'(bus.S_ARREADY), 64'd0);
    chk("rst_bvalid", 64'(bus.S_BVALID), 64'd0);
    chk("rst_rvalid", 64'(bus.S_RVALID), 64'd0);
    chk("rst_rdata", 64'(bus.S_RDATA), 64'd0);
    chk("rst_pulse", 64'(WR_PULSE), 64'd0);
    chk_regs("rst");
    ARESETN = 1'b1;
    tick();
    chk("rel_awready", 64'(bus.S_AWREADY), 64'd1);
    chk("rel_wready", 64'(bus.S_WREADY), 64'd1);
    chk("rel_arready", 64'(bus.S_ARREADY), 64'd1);

    // AW and W in the same cycle
    exp_reg[1] = 32'hDEADBEEF;
    write_both("wr1", 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 8'b0000_0010);

    // W three cycles ahead of AW
    bus.S_WDATA = 32'h12345678; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    chk("wfirst_wready", 64'(bus.S_WREADY), 64'd0);
    chk("wfirst_awready", 64'(bus.S_AWREADY), 64'd1);
    tick(); tick();
    chk("wfirst_nobvalid", 64'(bus.S_BVALID), 64'd0);
    chk("wfirst_reg2_old", 64'(REG_Q[2*32 +: 32]), 64'd0);
    bus.S_AWADDR = 32'h08; bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("wfirst_hs_bvalid", 64'(bus.S_BVALID), 64'd0);
    tick();
    exp_reg[2] = 32'h12345678;
    chk("wfirst_bvalid", 64'(bus.S_BVALID), 64'd1);
    chk("wfirst_pulse", 64'(WR_PULSE), 64'b0000_0100);
    chk_regs("wfirst");
    tick();

    // AW ahead of W
    bus.S_AWADDR = 32'h0C; bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("awfirst_awready", 64'(bus.S_AWREADY), 64'd0);
    chk("awfirst_wready", 64'(bus.S_WREADY), 64'd1);
    tick(); tick();
    chk("awfirst_nobvalid", 64'(bus.S_BVALID), 64'd0);
    bus.S_WDATA = 32'h12345678; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    tick();
    exp_reg[3] = 32'h12345678;
    chk("awfirst_bvalid", 64'(bus.S_BVALID), 64'd1);
    chk("awfirst_pulse", 64'(WR_PULSE), 64'b0000_1000);
    chk_regs("awfirst");
    tick();

    // Byte strobe and readback, including an unaligned address
    exp_reg[1] = 32'hDEADBEAA;
    write_both("strb", 32'h04, 32'h000000AA, 4'h1, 2'b00, 8'b0000_0010);
    read_chk("rd1", 32'h04, 32'hDEADBEAA, 2'b00);
    read_chk("rd_unal", 32'h0B, 32'h12345678, 2'b00);

    // Zero strobe: OKAY and a pulse, but no data change
    write_both("strb0", 32'h08, 32'hFFFFFFFF, 4'h0, 2'b00, 8'b0000_0100);

    // Out of range
    write_both("oor", 32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 8'b0000_0000);
    read_chk("rd_oor", 32'h40, 32'h0, 2'b10);

    // Write response backpressure
    bus.S_BREADY = 1'b0;
    bus.S_AWADDR = 32'h10; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = 32'h0BADF00D; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    tick();
    bus.S_AWADDR = 32'h14; bus.S_WDATA = 32'h55555555;
    tick();
    exp_reg[4] = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_bvalid_%0d", c), 64'(bus.S_BVALID), 64'd1);
      chk($sformatf("bp_bresp_%0d", c), 64'(bus.S_BRESP), 64'd0);
      chk($sformatf("bp_awready_%0d", c), 64'(bus.S_AWREADY), 64'd0);
      chk($sformatf("bp_wready_%0d", c), 64'(bus.S_WREADY), 64'd0);
      tick();
    end
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b1;
    tick();
    chk("bp_bdone", 64'(bus.S_BVALID), 64'd0);
    chk("bp_awready", 64'(bus.S_AWREADY), 64'd1);
    tick(); tick();
    chk_regs("bp");

    // Read response backpressure
    bus.S_RREADY = 1'b0;
    bus.S_ARADDR = 32'h10; bus.S_ARVALID = 1'b1;
    tick();
    bus.S_ARADDR = 32'h04;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rbp_rvalid_%0d", c), 64'(bus.S_RVALID), 64'd1);
      chk($sformatf("rbp_rdata_%0d", c), 64'(bus.S_RDATA), 64'h0BADF00D);
      chk($sformatf("rbp_arready_%0d", c), 64'(bus.S_ARREADY), 64'd0);
      tick();
    end
    bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b1;
    tick();
    chk("rbp_rdone", 64'(bus.S_RVALID), 64'd0);
    chk("rbp_arready", 64'(bus.S_ARREADY), 64'd1);

    // Reset after AW accepted but before W
    bus.S_AWADDR = 32'h18; bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("mid_aw_taken", 64'(bus.S_AWREADY), 64'd0);
    #2;
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_reg[i] = 32'h0;
    chk("mid_awready", 64'(bus.S_AWREADY), 64'd0);
    chk("mid_wready", 64'(bus.S_WREADY), 64'd0);
    chk("mid_arready", 64'(bus.S_ARREADY), 64'd0);
    chk("mid_bvalid", 64'(bus.S_BVALID), 64'd0);
    chk("mid_pulse", 64'(WR_PULSE), 64'd0);
    chk_regs("mid");
    tick();
    ARESETN = 1'b1;
    tick();
    bus.S_WDATA = 32'h11111111; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    chk("mid_w_taken", 64'(bus.S_WREADY), 64'd0);
    tick(); tick(); tick();
    chk("mid_nocommit_bvalid", 64'(bus.S_BVALID), 64'd0);
    chk("mid_nocommit_pulse", 64'(WR_PULSE), 64'd0);
    chk_regs("mid_nocommit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
AXI4-Lite subordinate (responder) exposing a bank of NUM_REGS word-addressed read/write registers. It is the other end of axi4_lite_master. It accepts AW and W independently and in either order, applies byte strobes, and returns OKAY or SLVERR responses. All register contents are driven out in parallel for fabric-side logic.

Parameters:
ADDRESS, 32, address width
DATA_WIDTH, 32, data width; multiple of 8 (32 or 64)
NUM_REGS, 8, number of registers; power of two, >= 2

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESETN  input  1  asynchronous active-low reset
S_AWADDR  input  ADDRESS  write address
S_AWVALID  input  1  write address valid
S_AWREADY  output  1  write address ready
S_WDATA  input  DATA_WIDTH  write data
S_WSTRB  input  DATA_WIDTH/8  byte strobes
S_WVALID  input  1  write data valid
S_WREADY  output  1  write data ready
S_BRESP  output  2  write response
S_BVALID  output  1  write response valid
S_BREADY  input  1  write response ready
S_ARADDR  input  ADDRESS  read address
S_ARVALID  input  1  read address valid
S_ARREADY  output  1  read address ready
S_RDATA  output  DATA_WIDTH  read data
S_RRESP  output  2  read response
S_RVALID  output  1  read data valid
S_RREADY  input  1  read data ready
REG_Q  output  NUM_REGS*DATA_WIDTH  all register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
WR_PULSE  output  NUM_REGS  one-cycle pulse per register on commit

Behaviour:
- Reset (async assert, sync release): all registers 0. All READY, VALID, RESP and RDATA outputs 0. WR_PULSE 0. Pending AW/W captures are discarded. S_AWREADY, S_WREADY and S_ARREADY rise on the first edge after ARESETN goes high.
- Decode: byte address. Register index = addr[log2(DATA_WIDTH/8) +: log2(NUM_REGS)].
- In range: addr < NUM_REGS*DATA_WIDTH/8. Out of range: write has no effect and returns SLVERR (2'b10). Read returns RDATA = 0 with SLVERR.
- Low unaligned bits are ignored. OKAY = 2'b00.
- Write capture: an AW handshake (VALID && READY) latches the address and drops S_AWREADY. A W handshake latches data and strobes and drops S_WREADY. The two channels are independent; either may arrive first or both in the same cycle.
- Write commit: at the edge after both are held (cycle C), selected bytes where WSTRB[b]=1 are updated. On the same edge S_BVALID=1 with BRESP, and the matching WR_PULSE bit is high for exactly one cycle (no pulse on SLVERR). Latency from the second handshake to BVALID is 1 cycle.
- Write response: S_BVALID and S_BRESP stay stable until S_BREADY. On the B handshake edge, BVALID clears and S_AWREADY/S_WREADY reassert. No new write is accepted while BVALID is pending, so at most one write is outstanding.
- Read: S_ARREADY is high when S_RVALID=0. An AR handshake at edge E registers RDATA/RRESP and sets S_RVALID=1 on E, with S_ARREADY low from E.
- Read response: RVALID, RDATA and RRESP stay stable until S_RREADY. The R handshake clears RVALID and reasserts ARREADY on that edge. Back-to-back reads therefore run at 1 per 2 cycles.
- Read and write are fully independent paths.
- Same-edge collision: if a read samples a register on the same edge a write commits to it, RDATA returns the old value (read-before-write).
- Every VALID output is held until handshake; it is never withdrawn except by reset.
- WSTRB = 0 in range: no bytes change, BRESP OKAY, WR_PULSE still fires.

Test Plan:
- Reset, then AW 0x04 and W 0xDEADBEEF/STRB 0xF in the same cycle, BREADY=1 -> BVALID 1 cycle after the handshake, BRESP 00, WR_PULSE[1] for one cycle, REG_Q reg1 = 0xDEADBEEF.
- W 0x12345678 sent 3 cycles before AW 0x08 -> WREADY low after the W handshake, commit only after AW, reg2 = 0x12345678. Repeat with AW first and the same result.
- reg1 = 0xDEADBEEF, then write 0x000000AA with STRB 0x1 -> reg1 = 0xDEADBEAA. Read 0x04 -> RDATA 0xDEADBEAA, RRESP 00.
- Write to and read from 0x40 (NUM_REGS=8) -> BRESP 10, no register changes, RDATA 0, RRESP 10.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY low, no second transaction accepted.
- Assert ARESETN low mid-write, after AW accepted but before W -> all outputs 0 immediately. After release, a fresh W alone does not commit.
